mul_accumulator: RTL
====================

// Module: mul_accumulator
// PURPOSE
//   Downstream consumer of the 8x8 unsigned combinational multiplier: takes its 16-bit product
//   with a valid/ready handshake and accumulates a group of products (dot-product style).
//   Emits the group sum on an output handshake, with a saturation flag and a term count.
//   Sits between the multiplier and the control unit's result register.
// PARAMETERS
//   ACC_W    24  accumulator/result width in bits; legal range ACC_W >= 16
//   N_TERMS  8   products per group before automatic close; legal range 1..15
//   CNT_W    4   term-counter width; must satisfy 2**CNT_W > N_TERMS
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   clear      in   1      synchronous abort: drop the current group, return to ACCUM
//   in_valid   in   1      prod/in_last valid
//   in_ready   out  1      block accepts a product this cycle
//   prod       in   16     unsigned product from the multiplier
//   in_last    in   1      this product closes the group early
//   out_valid  out  1      result valid; held until accepted
//   out_ready  in   1      consumer takes the result
//   acc_out    out  ACC_W  group sum, unsigned, saturated
//   out_sat    out  1      sticky: a clamp occurred in this group
//   out_count  out  CNT_W  number of products summed in this group
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=ACCUM; acc, count, sat = 0; out_valid=0. Effect is immediate, also mid-group.
//   - FSM has two states:
//       ACCUM: in_ready=1, out_valid=0.
//       HOLD:  in_ready=0, out_valid=1.
//   - Accept: in_valid & in_ready. On accept:
//       acc <= sat_add(acc, prod); count <= count+1; sat <= sat | overflow.
//       If count+1 == N_TERMS or in_last, go to HOLD next cycle.
//   - Latency: the result is visible on acc_out/out_count/out_sat on the cycle after the closing
//     accept. One bubble: no accept is possible in the HOLD cycle.
//   - HOLD: acc_out, out_count and out_sat stay stable while out_ready=0.
//     On out_ready=1: go to ACCUM, and acc, count, sat <= 0.
//   - in_valid=0 in ACCUM: no state change. A gap never closes a group.
//   - Saturating add: compute a (ACC_W+1)-bit sum of acc and zero-extended prod.
//     If the sum exceeds 2**ACC_W-1, the result is 2**ACC_W-1 and overflow=1.
//     Once acc is saturated it stays saturated.
//   - clear=1 has highest priority over accept and out_ready, in any state:
//       next state=ACCUM; acc, count, sat <= 0; out_valid=0; any same-cycle product is discarded.
//     in_ready is still driven per state, so an upstream stage may see a handshake that is dropped.
//   - All outputs are registered, except in_ready, which is decoded from state.
//   - prod is treated as unsigned. There is no signed mode.
// STRUCTURE
//   - Shared package mul_acc_pkg holds:
//       state encodings ST_ACCUM=1'b0, ST_HOLD=1'b1;
//       the ACC_W/N_TERMS defaults;
//       a compile-time check function for the parameter ranges.
//   - Sub-module sat_adder #(W) (a, b[15:0] -> sum[W-1:0], ovf): purely combinational saturating adder.
//   - The top level holds the FSM, the counter and the registers.
// TESTING
//   1. rst_n pulsed low mid-group after 3 accepts -> acc_out=0, out_count=0, out_valid=0, in_ready=1
//      while reset is asserted and after release.
//   2. 8 accepts of prod=65025 (255*255), ACC_W=24 -> next cycle out_valid=1, acc_out=520200,
//      out_count=8, out_sat=0.
//   3. prod=1, 2, 3 with in_last on the third, with 2-cycle in_valid gaps in between ->
//      acc_out=6, out_count=3, out_sat=0.
//   4. Hold out_ready=0 for 5 cycles after out_valid -> acc_out stable, in_ready=0, in_valid pulses
//      ignored. Then out_ready=1 -> one cycle later in_ready=1 and acc=0.
//   5. ACC_W=18, 8x prod=65025 -> acc_out=262143, out_sat=1, out_count=8.
//   6. clear=1 in the same cycle as an accept of prod=100, then prod=7 with in_last ->
//      acc_out=7, out_count=1. Also: clear during HOLD -> out_valid drops next cycle.

Source files
------------

// File: rtl/mul_acc_pkg.sv
// Shared definitions for the product accumulator.
//   - state_t        : two-state FSM encoding (ACCUM collects products, HOLD presents a result)
//   - *_DEFAULT      : default accumulator width, group length and counter width
//   - params_ok()    : elaboration-time legality check for the parameter set
package mul_acc_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam int ACC_W_DEFAULT   = 24;
    localparam int N_TERMS_DEFAULT = 8;
    localparam int CNT_W_DEFAULT   = 4;

    // The counter must be able to hold N_TERMS itself, hence 2**cnt_w > n_terms.
    function automatic bit params_ok(input int acc_w, input int n_terms, input int cnt_w);
        return (acc_w >= 16) && (n_terms >= 1) && (n_terms <= 15) &&
               ((1 << cnt_w) > n_terms);
    endfunction

endpackage

// File: rtl/sat_adder.sv
// Purely combinational unsigned saturating adder.
//   a   [W-1:0] : running sum
//   b   [15:0]  : product to add (zero-extended)
//   sum [W-1:0] : a+b, clamped to 2**W-1
//   ovf         : the true sum did not fit in W bits
module sat_adder #(
    parameter int W = 24
) (
    input  logic [W-1:0] a,
    input  logic [15:0]  b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] full_sum;

    // One extra bit catches the carry out; since both operands are unsigned
    // a saturated input plus any non-zero b carries out and stays clamped.
    assign full_sum = {1'b0, a} + {{(W + 1 - 16){1'b0}}, b};
    assign ovf      = full_sum[W];
    assign sum      = full_sum[W] ? {W{1'b1}} : full_sum[W-1:0];

endmodule

// File: rtl/mul_accumulator.sv
// Accumulates groups of 16-bit unsigned products into a saturating sum.
//   clk, rst_n            : clock, asynchronous active-low reset
//   clear                 : synchronous abort of the current group / pending result
//   in_valid, in_ready    : input handshake for prod/in_last
//   prod [15:0]           : unsigned product
//   in_last               : closes the group after this product
//   out_valid, out_ready  : output handshake for the result
//   acc_out [ACC_W-1:0]   : group sum (saturated)
//   out_sat               : a clamp occurred somewhere in the group
//   out_count [CNT_W-1:0] : number of products in the group
// A group closes after N_TERMS products or on in_last; the result is held
// until taken, during which no input is accepted.
module mul_accumulator
    import mul_acc_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEFAULT,
    parameter int N_TERMS = N_TERMS_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_sat,
    output logic [CNT_W-1:0] out_count
);

    if (!params_ok(ACC_W, N_TERMS, CNT_W)) begin : g_param_check
        $error("mul_accumulator: illegal ACC_W/N_TERMS/CNT_W combination");
    end

    state_t             state_reg;
    state_t             state_next;
    logic [ACC_W-1:0]   acc_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               sat_reg;

    logic [ACC_W-1:0]   add_sum;
    logic               add_ovf;
    logic [CNT_W-1:0]   count_inc;
    logic               accept;
    logic               close_group;
    logic               release_result;

    sat_adder #(
        .W (ACC_W)
    ) u_sat_adder (
        .a   (acc_reg),
        .b   (prod),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    assign count_inc      = count_reg + 1'b1;
    assign accept         = in_valid && in_ready;
    assign close_group    = accept && ((count_inc == CNT_W'(N_TERMS)) || in_last);
    assign release_result = (state_reg == ST_HOLD) && out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_ACCUM;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; clear overrides everything else
    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = ST_ACCUM;
        end else begin
            case (state_reg)
                ST_ACCUM: if (close_group)  state_next = ST_HOLD;
                ST_HOLD:  if (out_ready)    state_next = ST_ACCUM;
                default:                    state_next = ST_ACCUM;
            endcase
        end
    end

    // Output decode
    always_comb begin
        in_ready  = (state_reg == ST_ACCUM);
        out_valid = (state_reg == ST_HOLD);
    end

    // Datapath: sum, term count and sticky saturation flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg   <= '0;
            count_reg <= '0;
            sat_reg   <= 1'b0;
        end else if (clear || release_result) begin
            acc_reg   <= '0;
            count_reg <= '0;
            sat_reg   <= 1'b0;
        end else if (accept) begin
            acc_reg   <= add_sum;
            count_reg <= count_inc;
            sat_reg   <= sat_reg | add_ovf;
        end
    end

    assign acc_out   = acc_reg;
    assign out_count = count_reg;
    assign out_sat   = sat_reg;

endmodule
